// File: rtl/tm_qm0_pkg.sv
// ============================================================================
//  Module   : tm_qm0_pkg
//  Purpose  : Shared QM0 types and constants (queue-id width default,
//             active-tracker init length, active-tracker state encoding).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tm_qm0_pkg;

    localparam int QUEUE_BITS_DEF = 5;

    // Init covers one depth-RAM clear pass over all queues plus two cycles of
    // pipeline slack in the depth block.
    function automatic int init_cycles(input int qb);
        return (1 << qb) + 2;
    endfunction

    localparam int INIT_CYCLES = init_cycles(QUEUE_BITS_DEF);

    typedef enum logic [0:0] {
        ACT_INIT = 1'b0,
        ACT_RUN  = 1'b1
    } act_state_t;

endpackage

`default_nettype wire

// File: rtl/sfifo2f_fo.sv
// ============================================================================
//  Module   : sfifo2f_fo
//  Purpose  : Small synchronous FIFO with fall-through output (head entry is
//             visible on dout whenever empty is low). Push when full and pop
//             when empty are ignored.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sfifo2f_fo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage array; no reset needed since empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Read/write pointers carry one wrap bit to separate full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/tm_qm0_rr_arb.sv
// ============================================================================
//  Module   : tm_qm0_rr_arb
//  Purpose  : Combinational rotating-priority arbiter. Search begins at
//             ptr+1 (mod NQ) and the first set request wins; ptr itself is
//             the lowest priority.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tm_qm0_rr_arb #(
    parameter int QUEUE_BITS = 5
) (
    input  logic [(1<<QUEUE_BITS)-1:0] req,
    input  logic [QUEUE_BITS-1:0]      ptr,
    output logic [QUEUE_BITS-1:0]      grant,
    output logic                       grant_valid
);

    localparam int NQ = 1 << QUEUE_BITS;

    logic [QUEUE_BITS-1:0] cand;

    // Walk the ring once starting after ptr; keep the first hit.
    always_comb begin
        grant       = ptr;
        grant_valid = 1'b0;
        cand        = ptr;
        for (int i = 1; i <= NQ; i++) begin
            cand = ptr + QUEUE_BITS'(i);
            if (!grant_valid && req[cand]) begin
                grant       = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tm_qm0_q_active.sv
// ============================================================================
//  Module   : tm_qm0_q_active
//  Purpose  : QM0 active-queue tracker and round-robin dequeue scheduler in
//             front of tm_qm0_q_depth. Forwards enqueues, maintains the
//             active bitmap from depth responses, issues dequeues and reports
//             completed dequeues.
//  Config   : TM_QM0_ACT_BACK2BACK_EN - when defined, up to TRK_DEPTH
//             dequeues to distinct queues may be outstanding; otherwise only
//             one dequeue is outstanding at a time.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tm_qm0_q_active
    import tm_qm0_pkg::*;
#(
    parameter int QUEUE_BITS = QUEUE_BITS_DEF,
    parameter int TRK_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq_valid,
    input  logic [QUEUE_BITS-1:0] enq_qid,
    output logic                  enq_ready,
    input  logic                  deq_ready,
    output logic                  depth_enq_req,
    output logic [QUEUE_BITS-1:0] depth_enq_qid,
    output logic                  depth_deq_req,
    output logic [QUEUE_BITS-1:0] depth_deq_qid,
    input  logic                  depth_enq_ack,
    input  logic                  depth_enq_to_empty,
    input  logic                  depth_deq_ack,
    input  logic                  depth_deq_from_emptyp2,
    output logic                  deq_done_valid,
    output logic [QUEUE_BITS-1:0] deq_done_qid,
    output logic                  deq_done_last,
    output logic                  active_any
);

    localparam int NQ = 1 << QUEUE_BITS;
    localparam logic [QUEUE_BITS:0] INIT_LAST = (QUEUE_BITS+1)'(init_cycles(QUEUE_BITS) - 1);

    act_state_t            state;
    act_state_t            state_nxt;
    logic [QUEUE_BITS:0]   init_cnt;
    logic                  run;

    logic [NQ-1:0]         active;
    logic [NQ-1:0]         inflight;
    logic [NQ-1:0]         eligible;
    logic [QUEUE_BITS-1:0] rr;
    logic [QUEUE_BITS-1:0] winner;
    logic                  win_valid;

    logic                  enq_accept;
    logic                  enq_ack_ok;
    logic                  enq_trk_full;
    logic                  enq_trk_empty;
    logic [QUEUE_BITS-1:0] enq_head;

    logic                  deq_issue;
    logic                  deq_ack_ok;
    logic                  deq_trk_full;
    logic                  deq_trk_empty;
    logic [QUEUE_BITS-1:0] deq_head;

    // State register and init counter; counter only advances while in INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACT_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ACT_INIT) init_cnt <= init_cnt + (QUEUE_BITS+1)'(1);
        end
    end

    // Leave INIT once the depth RAM clear window has elapsed.
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        case (state)
            ACT_INIT: if (init_cnt == INIT_LAST) state_nxt = ACT_RUN;
            ACT_RUN:  run = 1'b1;
        endcase
    end

    assign enq_ready  = run & ~enq_trk_full;
    assign enq_accept = enq_valid & enq_ready;
    assign enq_ack_ok = depth_enq_ack & ~enq_trk_empty;
    assign deq_ack_ok = depth_deq_ack & ~deq_trk_empty;
    assign eligible   = active & ~inflight;
    assign deq_issue  = run & deq_ready & win_valid & ~deq_trk_full;
    assign active_any = |active;

    sfifo2f_fo #(.WIDTH(QUEUE_BITS), .DEPTH(TRK_DEPTH)) u_enq_trk (
        .clk   (clk),
        .reset (reset),
        .push  (enq_accept),
        .din   (enq_qid),
        .pop   (enq_ack_ok),
        .dout  (enq_head),
        .full  (enq_trk_full),
        .empty (enq_trk_empty)
    );

`ifdef TM_QM0_ACT_BACK2BACK_EN
    sfifo2f_fo #(.WIDTH(QUEUE_BITS), .DEPTH(TRK_DEPTH)) u_deq_trk (
        .clk   (clk),
        .reset (reset),
        .push  (deq_issue),
        .din   (winner),
        .pop   (deq_ack_ok),
        .dout  (deq_head),
        .full  (deq_trk_full),
        .empty (deq_trk_empty)
    );
`else
    logic                  deq_slot_valid;
    logic [QUEUE_BITS-1:0] deq_slot_qid;

    // Single outstanding dequeue: the slot blocks issue until its ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            deq_slot_valid <= 1'b0;
            deq_slot_qid   <= '0;
        end else if (deq_issue) begin
            deq_slot_valid <= 1'b1;
            deq_slot_qid   <= winner;
        end else if (deq_ack_ok) begin
            deq_slot_valid <= 1'b0;
        end
    end

    assign deq_trk_full  = deq_slot_valid;
    assign deq_trk_empty = ~deq_slot_valid;
    assign deq_head      = deq_slot_qid;
`endif

    tm_qm0_rr_arb #(.QUEUE_BITS(QUEUE_BITS)) u_arb (
        .req         (eligible),
        .ptr         (rr),
        .grant       (winner),
        .grant_valid (win_valid)
    );

    // Forward accepted enqueue notifications to the depth block.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_enq_req <= 1'b0;
            depth_enq_qid <= '0;
        end else begin
            depth_enq_req <= enq_accept;
            if (enq_accept) depth_enq_qid <= enq_qid;
        end
    end

    // Issue register and rr pointer; rr only moves on an actual issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_deq_req <= 1'b0;
            depth_deq_qid <= '0;
            rr            <= '1;
        end else begin
            depth_deq_req <= deq_issue;
            if (deq_issue) begin
                depth_deq_qid <= winner;
                rr            <= winner;
            end
        end
    end

    // Active bitmap; the set is written last so it wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= '0;
        end else begin
            if (deq_ack_ok && !depth_deq_from_emptyp2) active[deq_head] <= 1'b0;
            if (enq_ack_ok && depth_enq_to_empty)      active[enq_head] <= 1'b1;
        end
    end

    // In-flight mask; a same-cycle issue keeps the bit set over an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            if (deq_ack_ok) inflight[deq_head] <= 1'b0;
            if (deq_issue)  inflight[winner]   <= 1'b1;
        end
    end

    // Completion report, one cycle after the depth block's dequeue ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            deq_done_valid <= 1'b0;
            deq_done_qid   <= '0;
            deq_done_last  <= 1'b0;
        end else begin
            deq_done_valid <= deq_ack_ok;
            deq_done_last  <= deq_ack_ok & ~depth_deq_from_emptyp2;
            if (deq_ack_ok) deq_done_qid <= deq_head;
        end
    end

`ifndef SYNTHESIS
    // Acks are only legal while a matching request is outstanding.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(depth_enq_ack && enq_trk_empty))
                else $error("tm_qm0_q_active: enqueue ack with no outstanding enqueue");
            assert (!(depth_deq_ack && deq_trk_empty))
                else $error("tm_qm0_q_active: dequeue ack with no outstanding dequeue");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tm_qm0_q_active.sv
// ============================================================================
//  Module   : tb_tm_qm0_q_active
//  Purpose  : Directed self-checking bench for tm_qm0_q_active with a small
//             depth-block responder (enq ack 2 cycles, deq ack 3 cycles after
//             request) that can be switched to manual ack control.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tm_qm0_q_active;
    import tm_qm0_pkg::*;

    localparam int QB = QUEUE_BITS_DEF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enq_valid = 1'b0;
    logic [QB-1:0] enq_qid = '0;
    logic          enq_ready;
    logic          deq_ready = 1'b0;
    logic          depth_enq_req;
    logic [QB-1:0] depth_enq_qid;
    logic          depth_deq_req;
    logic [QB-1:0] depth_deq_qid;
    logic          depth_enq_ack;
    logic          depth_enq_to_empty;
    logic          depth_deq_ack;
    logic          depth_deq_from_emptyp2;
    logic          deq_done_valid;
    logic [QB-1:0] deq_done_qid;
    logic          deq_done_last;
    logic          active_any;

    logic auto_ack = 1'b1;
    logic m_enq_ack = 1'b0, m_to_empty = 1'b0, m_deq_ack = 1'b0, m_emptyp2 = 1'b0;

    logic [1:0]    e_v;
    logic [2:0]    d_v;
    logic [QB-1:0] e_q0, e_q1, d_q0, d_q1, d_q2;
    int            cnt [32];
    logic          a_enq_ack, a_deq_ack, a_to_empty, a_emptyp2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    tm_qm0_q_active dut (
        .clk                    (clk),
        .reset                  (reset),
        .enq_valid              (enq_valid),
        .enq_qid                (enq_qid),
        .enq_ready              (enq_ready),
        .deq_ready              (deq_ready),
        .depth_enq_req          (depth_enq_req),
        .depth_enq_qid          (depth_enq_qid),
        .depth_deq_req          (depth_deq_req),
        .depth_deq_qid          (depth_deq_qid),
        .depth_enq_ack          (depth_enq_ack),
        .depth_enq_to_empty     (depth_enq_to_empty),
        .depth_deq_ack          (depth_deq_ack),
        .depth_deq_from_emptyp2 (depth_deq_from_emptyp2),
        .deq_done_valid         (deq_done_valid),
        .deq_done_qid           (deq_done_qid),
        .deq_done_last          (deq_done_last),
        .active_any             (active_any)
    );

    // Depth-block responder model: per-queue depth counts.
    assign a_enq_ack  = e_v[1];
    assign a_deq_ack  = d_v[2];
    assign a_to_empty = (cnt[e_q1] == 0);
    assign a_emptyp2  = (cnt[d_q2] >= 2);

    assign depth_enq_ack          = auto_ack ? a_enq_ack  : m_enq_ack;
    assign depth_enq_to_empty     = auto_ack ? a_to_empty : m_to_empty;
    assign depth_deq_ack          = auto_ack ? a_deq_ack  : m_deq_ack;
    assign depth_deq_from_emptyp2 = auto_ack ? a_emptyp2  : m_emptyp2;

    // Responder pipelines and depth bookkeeping.
    always @(posedge clk) begin
        if (reset) begin
            e_v <= '0;
            d_v <= '0;
            for (int i = 0; i < 32; i++) cnt[i] <= 0;
        end else begin
            e_v  <= {e_v[0], depth_enq_req & auto_ack};
            e_q0 <= depth_enq_qid;
            e_q1 <= e_q0;
            d_v  <= {d_v[1:0], depth_deq_req & auto_ack};
            d_q0 <= depth_deq_qid;
            d_q1 <= d_q0;
            d_q2 <= d_q1;
            if (!(a_enq_ack && a_deq_ack && e_q1 == d_q2)) begin
                if (a_enq_ack) cnt[e_q1] <= cnt[e_q1] + 1;
                if (a_deq_ack) cnt[d_q2] <= cnt[d_q2] - 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic enq(input logic [QB-1:0] q);
        logic acc;
        acc = 1'b0;
        enq_valid = 1'b1;
        enq_qid   = q;
        for (int k = 0; k < 50; k++) begin
            acc = enq_ready;
            step();
            if (acc) break;
        end
        enq_valid = 1'b0;
        checks++;
        if (!acc) begin errors++; $display("FAIL enq_accept_timeout: qid %0d got not-accepted expected accepted", q); end
    endtask

    task automatic test_reset();
        int n;
        logic early;
        reset = 1'b1;
        step();
        step();
        checks++; if (enq_ready !== 1'b0)      begin errors++; $display("FAIL reset_enq_ready: got %0b expected 0", enq_ready); end
        checks++; if (depth_enq_req !== 1'b0)  begin errors++; $display("FAIL reset_depth_enq_req: got %0b expected 0", depth_enq_req); end
        checks++; if (depth_deq_req !== 1'b0)  begin errors++; $display("FAIL reset_depth_deq_req: got %0b expected 0", depth_deq_req); end
        checks++; if (deq_done_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_done_valid: got %0b expected 0", deq_done_valid); end
        checks++; if (active_any !== 1'b0)     begin errors++; $display("FAIL reset_active_any: got %0b expected 0", active_any); end
        reset = 1'b0;
        deq_ready = 1'b1;
        n = 0;
        early = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 2) begin enq_valid = 1'b1; enq_qid = 5'd3; end
            if (depth_enq_req) early = 1'b1;
            if (enq_ready) begin n = k; break; end
        end
        checks++; if (n != INIT_CYCLES) begin errors++; $display("FAIL init_length: got %0d expected %0d", n, INIT_CYCLES); end
        checks++; if (early !== 1'b0)    begin errors++; $display("FAIL init_no_enq_req: got %0b expected 0", early); end
        step();
        enq_valid = 1'b0;
        checks++; if (depth_enq_req !== 1'b1) begin errors++; $display("FAIL first_enq_req: got %0b expected 1", depth_enq_req); end
        checks++; if (depth_enq_qid !== 5'd3) begin errors++; $display("FAIL first_enq_qid: got %0d expected 3", depth_enq_qid); end
    endtask

    task automatic test_single_q3();
        logic seen;
        int t0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); if (depth_enq_ack) begin seen = 1'b1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL q3_enq_ack_timeout: got 0 expected 1"); end
        checks++; if (active_any !== 1'b0) begin errors++; $display("FAIL q3_active_before_set: got %0b expected 0", active_any); end
        step();
        checks++; if (active_any !== 1'b1) begin errors++; $display("FAIL q3_active_set: got %0b expected 1", active_any); end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); if (depth_deq_req) begin seen = 1'b1; break; end end
        t0 = cyc;
        checks++; if (!seen || depth_deq_qid !== 5'd3) begin errors++; $display("FAIL q3_deq_issue: got req %0b qid %0d expected req 1 qid 3", seen, depth_deq_qid); end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); if (deq_done_valid) begin seen = 1'b1; break; end end
        checks++; if (!seen || deq_done_qid !== 5'd3) begin errors++; $display("FAIL q3_done_qid: got valid %0b qid %0d expected valid 1 qid 3", seen, deq_done_qid); end
        checks++; if (deq_done_last !== 1'b1) begin errors++; $display("FAIL q3_done_last: got %0b expected 1", deq_done_last); end
        checks++; if (active_any !== 1'b0)    begin errors++; $display("FAIL q3_active_cleared: got %0b expected 0", active_any); end
        checks++; if (cyc - t0 != 4)          begin errors++; $display("FAIL q3_req_to_done: got %0d expected 4", cyc - t0); end
    endtask

    task automatic test_round_robin();
        logic [QB-1:0] qs [3];
        int exp_q [9];
        int got_q [9];
        int t [9];
        int idx;
        qs = '{5'd1, 5'd7, 5'd30};
        exp_q = '{7, 30, 1, 7, 30, 1, 7, 30, 1};
        for (int i = 0; i < 9; i++) begin got_q[i] = -1; t[i] = 0; end
        deq_ready = 1'b0;
        for (int r = 0; r < 3; r++) for (int i = 0; i < 3; i++) enq(qs[i]);
        repeat (6) step();
        checks++; if (active_any !== 1'b1) begin errors++; $display("FAIL rr_loaded_active: got %0b expected 1", active_any); end
        deq_ready = 1'b1;
        idx = 0;
        for (int k = 0; k < 120 && idx < 9; k++) begin
            step();
            if (depth_deq_req) begin got_q[idx] = int'(depth_deq_qid); t[idx] = cyc; idx++; end
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
`ifdef TM_QM0_ACT_BACK2BACK_EN
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (t[i] - t[i-1] != 1) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 1", i, t[i] - t[i-1]); end
        end
`else
        for (int i = 1; i < 9; i++) begin
            checks++;
            if (t[i] - t[i-1] != 5) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 5", i, t[i] - t[i-1]); end
        end
`endif
        repeat (10) step();
        deq_ready = 1'b0;
        checks++; if (active_any !== 1'b0) begin errors++; $display("FAIL rr_drained: got %0b expected 0", active_any); end
    endtask

    task automatic test_depth3();
        logic exp_last [3];
        logic exp_act [3];
        int n;
        exp_last = '{1'b0, 1'b0, 1'b1};
        exp_act  = '{1'b1, 1'b1, 1'b0};
        deq_ready = 1'b0;
        repeat (3) enq(5'd5);
        repeat (6) step();
        deq_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 80 && n < 3; k++) begin
            step();
            if (deq_done_valid) begin
                checks++; if (deq_done_qid !== 5'd5) begin errors++; $display("FAIL d3_qid[%0d]: got %0d expected 5", n, deq_done_qid); end
                checks++; if (deq_done_last !== exp_last[n]) begin errors++; $display("FAIL d3_last[%0d]: got %0b expected %0b", n, deq_done_last, exp_last[n]); end
                checks++; if (active_any !== exp_act[n]) begin errors++; $display("FAIL d3_active[%0d]: got %0b expected %0b", n, active_any, exp_act[n]); end
                n++;
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL d3_done_count: got %0d expected 3", n); end
        deq_ready = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_same_cycle();
        logic seen;
        auto_ack = 1'b0;
        deq_ready = 1'b0;
        enq(5'd9);
        m_enq_ack = 1'b1; m_to_empty = 1'b1;
        step();
        m_enq_ack = 1'b0; m_to_empty = 1'b0;
        checks++; if (active_any !== 1'b1) begin errors++; $display("FAIL sc_q9_active: got %0b expected 1", active_any); end
        enq(5'd9);
        deq_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); if (depth_deq_req) begin seen = 1'b1; break; end end
        deq_ready = 1'b0;
        checks++; if (!seen || depth_deq_qid !== 5'd9) begin errors++; $display("FAIL sc_issue: got req %0b qid %0d expected req 1 qid 9", seen, depth_deq_qid); end
        m_enq_ack = 1'b1; m_to_empty = 1'b1; m_deq_ack = 1'b1; m_emptyp2 = 1'b0;
        step();
        m_enq_ack = 1'b0; m_to_empty = 1'b0; m_deq_ack = 1'b0;
        checks++; if (deq_done_valid !== 1'b1 || deq_done_qid !== 5'd9) begin errors++; $display("FAIL sc_done: got valid %0b qid %0d expected valid 1 qid 9", deq_done_valid, deq_done_qid); end
        checks++; if (deq_done_last !== 1'b1) begin errors++; $display("FAIL sc_done_last: got %0b expected 1", deq_done_last); end
        checks++; if (active_any !== 1'b1)    begin errors++; $display("FAIL sc_set_wins: got %0b expected 1", active_any); end
        deq_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); if (depth_deq_req) begin seen = 1'b1; break; end end
        deq_ready = 1'b0;
        checks++; if (!seen || depth_deq_qid !== 5'd9) begin errors++; $display("FAIL sc_reissue: got req %0b qid %0d expected req 1 qid 9", seen, depth_deq_qid); end
        m_deq_ack = 1'b1; m_emptyp2 = 1'b0;
        step();
        m_deq_ack = 1'b0;
        checks++; if (active_any !== 1'b0) begin errors++; $display("FAIL sc_cleared: got %0b expected 0", active_any); end
        auto_ack = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_backpressure();
        int exp_q [4];
        int got_q [4];
        int idx;
        logic bad;
        exp_q = '{10, 20, 25, 2};
        for (int i = 0; i < 4; i++) got_q[i] = -1;
        deq_ready = 1'b0;
        enq(5'd2); enq(5'd10); enq(5'd20); enq(5'd25);
        repeat (6) step();
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); if (depth_deq_req) bad = 1'b1; end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bp_no_issue: got %0b expected 0", bad); end
        checks++; if (active_any !== 1'b1) begin errors++; $display("FAIL bp_active_held: got %0b expected 1", active_any); end
        deq_ready = 1'b1;
        idx = 0;
        for (int k = 0; k < 60 && idx < 4; k++) begin
            step();
            if (depth_deq_req) begin got_q[idx] = int'(depth_deq_qid); idx++; end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
        repeat (10) step();
        deq_ready = 1'b0;
        checks++; if (active_any !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b expected 0", active_any); end
    endtask

    initial begin
        test_reset();
        test_single_q3();
        test_round_robin();
        test_depth3();
        test_same_cycle();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tm_qm0_q_active.md
# tm_qm0_q_active

Active-queue tracker and round-robin dequeue scheduler for QM0; it sits directly upstream of tm_qm0_q_depth. It accepts enqueue notifications from the egress processor and forwards them to the depth block. It keeps a per-queue active bitmap built from the depth block's to-empty and from-2-or-more responses, and issues at most one dequeue per cycle to the next active queue in round-robin order. Each completed dequeue is reported to the link-list stage.

## Interface
- QUEUE_BITS, 5, queue-id width; NQ = 2^QUEUE_BITS queues
- TRK_DEPTH, 4, entries in each in-order qid tracking FIFO (power of 2)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enq_valid  in  1  egress enqueue notification
- enq_qid  in  QUEUE_BITS  queue enqueued to
- enq_ready  out  1  notification accepted when enq_valid&enq_ready
- deq_ready  in  1  downstream can accept a dequeue issue
- depth_enq_req / depth_enq_qid  out  1 / QUEUE_BITS  to tm_qm0_q_depth
- depth_deq_req / depth_deq_qid  out  1 / QUEUE_BITS  to tm_qm0_q_depth
- depth_enq_ack, depth_enq_to_empty  in  1, 1  in-order enqueue response
- depth_deq_ack, depth_deq_from_emptyp2  in  1, 1  in-order dequeue response
- deq_done_valid  out  1  dequeue completed
- deq_done_qid  out  QUEUE_BITS  queue dequeued
- deq_done_last  out  1  queue became empty by this dequeue
- active_any  out  1  OR of active bitmap

## Operation
- Init: after reset, a counter runs NQ+2 cycles to cover the depth RAM clear. enq_ready=0 and no deq issue until the count completes, then the INIT state goes to RUN. Reset in any state returns to INIT, clears the bitmap, in-flight mask and FIFOs.
- Enqueue path:
  - enq_ready = RUN & ~enq_trk_full.
  - An accepted notification registers depth_enq_req=1 and depth_enq_qid the next cycle, and pushes the qid into enq_trk.
  - On depth_enq_ack, pop enq_trk. If depth_enq_to_empty, set active[qid].
- Dequeue path:
  - Eligible = active & ~inflight.
  - Round-robin pointer rr: search starts at rr+1 mod NQ; the first eligible qid wins.
  - Issue when RUN & deq_ready & |eligible & ~deq_trk_full. Issue registers depth_deq_req=1 with depth_deq_qid=winner, sets inflight[winner], pushes winner into deq_trk, and sets rr=winner.
  - On depth_deq_ack, pop deq_trk (qid q) and clear inflight[q]. If ~depth_deq_from_emptyp2, clear active[q] and set deq_done_last.
  - deq_done_valid/qid/last are registered one cycle after depth_deq_ack.
- Simultaneous events:
  - Set and clear of the same active bit in one cycle: set wins.
  - Issue and ack of the same qid in one cycle: inflight stays set.
  - Enqueue and dequeue issue may both occur in the same cycle.
- An ack with its tracking FIFO empty is a protocol error: ignore it, and a sim-only assertion fires.
- Arithmetic: rr and counters wrap modulo their width. The init counter is QUEUE_BITS+1 bits wide.

## Timing
- Reset values:
  - All outputs 0, including enq_ready=0.
  - rr = NQ-1, so the first search starts at qid 0.
- enq_valid → depth_enq_req: 1 cycle.
- Selection → depth_deq_req: 1 cycle (registered). A new issue is possible every cycle.
- The depth block acks a dequeue 3 cycles after the request.
- depth_deq_ack → deq_done_valid: 1 cycle. The active bit updates in the same edge as deq_done_valid.
- depth_enq_ack → active bit set: 1 cycle. That queue is eligible for issue in the cycle after the bit sets.
- Back-pressure: deq_ready low holds issue, and the rr pointer does not move.

## Configuration
- TM_QM0_ACT_BACK2BACK_EN defined: pipelined issue is allowed, up to TRK_DEPTH outstanding dequeues to distinct queues (inflight mask).
- Not defined: at most one dequeue outstanding in total. Issue is blocked from a request until its deq_done_valid, and deq_trk reduces to a single register.

## Structure
- Shared package tm_qm0_pkg holds:
  - the QUEUE_BITS default;
  - the INIT_CYCLES constant (NQ+2);
  - the state enum {ACT_INIT, ACT_RUN}.
- One sub-module: tm_qm0_rr_arb (NQ-wide rotating priority arbiter: req vector and pointer in, grant index and grant-valid out, combinational).
- The tracking FIFOs reuse the existing sfifo2f_fo.

## Test plan
- Reset, then enq_valid at cycle 2 → enq_ready held 0 until cycle NQ+2, and no depth_enq_req before then.
- Enqueue q3 with ack to_empty=1 → active[3]=1. Issue deq q3, ack from_emptyp2=0 → deq_done_valid, qid=3, last=1; active_any falls to 0.
- Queues 1, 7, 30 active and deq_ready=1 throughout → issue order 1, 7, 30, 1, … with back-to-back requests. Macro undefined → one issue every ≥5 cycles.
- Queue 5 active with depth 3 → two acks with from_emptyp2=1 keep active[5]=1. The third ack clears it, with deq_done_last=1 only on the third.
- Same-cycle enq ack (to_empty=1) and deq ack (from_emptyp2=0) on q9 → active[9]=1 afterwards.
- Hold deq_ready=0 for 10 cycles with 4 queues active → no depth_deq_req and rr unchanged; on release, resume at the next qid after rr.
